// File: rtl/ax_branch_chooser_pkg.sv
// Shared fetch-unit types for the AX/BTB branch chooser.
// Default table geometry, counter width and the chooser FSM states.
package FetchUnitTypes;

  localparam int PC_WIDTH = 32;
  localparam int CHOOSER_ENTRY_NUM = 256;
  localparam int CHOOSER_INDEX_WIDTH = $clog2(CHOOSER_ENTRY_NUM);
  localparam int CHOOSER_CNT_WIDTH = 2;

  typedef logic [PC_WIDTH-1:0] PC_Path;
  typedef logic [CHOOSER_INDEX_WIDTH-1:0] ChooserIndexPath;
  typedef logic [CHOOSER_CNT_WIDTH-1:0] ChooserCntPath;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ChooserState;

endpackage

// File: rtl/chooser_counter_table.sv
// Chooser counter storage: one write port, asynchronous read ports.
// Contents are not reset; the owner sweeps an init value after reset.
module chooser_counter_table #(
  parameter int ENTRY_NUM = 256,
  parameter int CNT_WIDTH = 2,
  parameter int RD_PORTS = 2,
  localparam int IDX_W = $clog2(ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [CNT_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]     i_raddr [RD_PORTS],
  output logic [CNT_WIDTH-1:0] o_rdata [RD_PORTS]
);

  logic [CNT_WIDTH-1:0] r_mem [ENTRY_NUM];

  // single synchronous write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // combinational reads, one per port
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      o_rdata[i] = r_mem[i_raddr[i]];
    end
  end

endmodule

// File: rtl/ax_branch_chooser.sv
// Chooses per lane between baseline BTB and AXBTB using saturating
// counters; first taken lane wins, counters trained by resolved branches.
module ax_branch_chooser #(
  parameter int FETCH_WIDTH = 2,
  parameter int CHOOSER_ENTRY_NUM = 256,
  parameter int CNT_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FETCH_WIDTH-1:0] fetchStageIsValid,
  input  FetchUnitTypes::PC_Path fetchStagePC [FETCH_WIDTH],
  input  logic [FETCH_WIDTH-1:0] btbHit,
  input  FetchUnitTypes::PC_Path btbOut [FETCH_WIDTH],
  input  logic [FETCH_WIDTH-1:0] axbtbHit,
  input  FetchUnitTypes::PC_Path axbtbOut [FETCH_WIDTH],
  input  logic                   updValid,
  input  FetchUnitTypes::PC_Path updPC,
  input  logic                   updBtbCorrect,
  input  logic                   updAxCorrect,
  output logic [FETCH_WIDTH-1:0] brDecidTaken,
  output FetchUnitTypes::PC_Path decidTarget [FETCH_WIDTH],
  output logic [FETCH_WIDTH-1:0] decidUseAx,
  output logic                   initDone
);

  import FetchUnitTypes::*;

  localparam int IDX_W = $clog2(CHOOSER_ENTRY_NUM);
  localparam int RD_N = FETCH_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] INIT_VAL =
    CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  ChooserState          r_state;
  ChooserState          w_next_state;
  logic [IDX_W-1:0]     r_sweep;
  logic [IDX_W-1:0]     w_raddr [RD_N];
  logic [CNT_WIDTH-1:0] w_rdata [RD_N];
  logic                 w_we;
  logic [IDX_W-1:0]     w_waddr;
  logic [CNT_WIDTH-1:0] w_wdata;
  logic [CNT_WIDTH-1:0] w_upd_cnt;
  logic                 w_run;
  logic                 w_inc;
  logic                 w_dec;
  logic                 w_seen;
  logic [FETCH_WIDTH-1:0] w_use_ax;
  logic [FETCH_WIDTH-1:0] w_raw;
  logic                 w_unused_pc;

  // lane read ports plus one extra port for the update read-modify-write
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_raddr[i] = fetchStagePC[i][IDX_W+1:2];
    end
    w_raddr[FETCH_WIDTH] = updPC[IDX_W+1:2];
  end

  // PC bits outside the index field do not affect the chooser
  always_comb begin
    w_unused_pc = ^{updPC[PC_WIDTH-1:IDX_W+2], updPC[1:0]};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_unused_pc = w_unused_pc ^
        (^{fetchStagePC[i][PC_WIDTH-1:IDX_W+2], fetchStagePC[i][1:0]});
    end
  end

  chooser_counter_table #(
    .ENTRY_NUM (CHOOSER_ENTRY_NUM),
    .CNT_WIDTH (CNT_WIDTH),
    .RD_PORTS  (RD_N)
  ) u_table (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_upd_cnt = w_rdata[FETCH_WIDTH];
  assign w_run = (r_state == RUN);
  assign initDone = w_run;
  assign w_inc = updValid & updAxCorrect & ~updBtbCorrect &
                 (w_upd_cnt != CNT_MAX);
  assign w_dec = updValid & updBtbCorrect & ~updAxCorrect &
                 (w_upd_cnt != '0);

  // state register and init sweep pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == INIT) begin
        r_sweep <= r_sweep + 1'b1;
      end
    end
  end

  // next state and table write: init sweep, then saturating training
  always_comb begin
    w_next_state = r_state;
    w_we = 1'b0;
    w_waddr = r_sweep;
    w_wdata = INIT_VAL;
    unique case (r_state)
      INIT: begin
        w_we = 1'b1;
        if (r_sweep == '1) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_waddr = w_raddr[FETCH_WIDTH];
        w_we = w_inc | w_dec;
        w_wdata = w_inc ? (w_upd_cnt + 1'b1) : (w_upd_cnt - 1'b1);
      end
      default: w_next_state = INIT;
    endcase
  end

  // per-lane source select and first-taken masking
  always_comb begin
    w_seen = 1'b0;
    w_use_ax = '0;
    w_raw = '0;
    brDecidTaken = '0;
    decidUseAx = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_use_ax[i] = w_run & w_rdata[i][CNT_WIDTH-1];
      w_raw[i] = fetchStageIsValid[i] &
                 (w_use_ax[i] ? axbtbHit[i] : btbHit[i]);
      brDecidTaken[i] = w_raw[i] & ~w_seen;
      w_seen = w_seen | w_raw[i];
      decidTarget[i] = w_use_ax[i] ? axbtbOut[i] : btbOut[i];
      decidUseAx[i] = w_use_ax[i] & fetchStageIsValid[i];
    end
  end

endmodule

// File: tb/tb_ax_branch_chooser.sv
// Self-checking bench for ax_branch_chooser (default parameters).
// Directed scenarios plus randomized traffic against a counter model.
module tb_ax_branch_chooser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  valid;
  logic [31:0] pc [2];
  logic [1:0]  btbHit;
  logic [31:0] btbOut [2];
  logic [1:0]  axHit;
  logic [31:0] axOut [2];
  logic        updValid;
  logic [31:0] updPC;
  logic        updBtbCorrect;
  logic        updAxCorrect;
  logic [1:0]  brDecidTaken;
  logic [31:0] decidTarget [2];
  logic [1:0]  decidUseAx;
  logic        initDone;

  int n_pass = 0;
  int n_chk = 0;
  int mcnt [256];
  bit m_run = 1'b0;

  always #5 clk = ~clk;

  ax_branch_chooser #(
    .FETCH_WIDTH(2),
    .CHOOSER_ENTRY_NUM(256),
    .CNT_WIDTH(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fetchStageIsValid (valid),
    .fetchStagePC      (pc),
    .btbHit            (btbHit),
    .btbOut            (btbOut),
    .axbtbHit          (axHit),
    .axbtbOut          (axOut),
    .updValid          (updValid),
    .updPC             (updPC),
    .updBtbCorrect     (updBtbCorrect),
    .updAxCorrect      (updAxCorrect),
    .brDecidTaken      (brDecidTaken),
    .decidTarget       (decidTarget),
    .decidUseAx        (decidUseAx),
    .initDone          (initDone)
  );

  function automatic int idx_of(logic [31:0] p);
    return int'(p[9:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mcnt[i] = 1;
  endtask

  task automatic set_lane(int l, logic v, logic [31:0] p,
                          logic bh, logic [31:0] bo,
                          logic ah, logic [31:0] ao);
    valid[l] = v;
    pc[l] = p;
    btbHit[l] = bh;
    btbOut[l] = bo;
    axHit[l] = ah;
    axOut[l] = ao;
  endtask

  task automatic set_upd(logic v, logic [31:0] p, logic bc, logic ac);
    updValid = v;
    updPC = p;
    updBtbCorrect = bc;
    updAxCorrect = ac;
  endtask

  // advance one clock; the model learns what the DUT sees at the edge
  task automatic tick();
    int k;
    if (m_run && updValid) begin
      k = idx_of(updPC);
      if (updAxCorrect && !updBtbCorrect && mcnt[k] < 3) mcnt[k]++;
      else if (updBtbCorrect && !updAxCorrect && mcnt[k] > 0) mcnt[k]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    set_lane(0, 0, 0, 0, 0, 0, 0);
    set_lane(1, 0, 0, 0, 0, 0, 0);
    set_upd(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    #2;
    n_chk++;
    if (initDone !== 1'b0)
      $display("FAIL reset_initDone: got %b expected 0", initDone);
    else n_pass++;
    n_chk++;
    if (decidUseAx !== 2'b00)
      $display("FAIL reset_useAx: got %b expected 00", decidUseAx);
    else n_pass++;
    n_chk++;
    if (brDecidTaken !== 2'b00)
      $display("FAIL reset_taken: got %b expected 00", brDecidTaken);
    else n_pass++;
    set_lane(0, 1, 32'h100, 1, 32'h200, 1, 32'h300);
    #1;
    n_chk++;
    if (decidUseAx !== 2'b00 || decidTarget[0] !== 32'h200)
      $display("FAIL init_lane_btb: got useAx=%b tgt=%h expected 00/200",
               decidUseAx, decidTarget[0]);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_init();
    int cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    m_run = 1'b0;
    set_upd(1, 32'h100, 0, 1);
    while (initDone !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    set_upd(0, 0, 0, 0);
    n_chk++;
    if (cyc != 256)
      $display("FAIL init_cycles: got %0d expected 256", cyc);
    else n_pass++;
    model_reset();
    m_run = 1'b1;
    for (int e = 0; e < 256; e++) begin
      logic [31:0] p;
      p = 32'h7000_0000 | (32'(e) << 2);
      set_lane(0, 1, p, 1, 32'(e), 0, ~32'(e));
      #1;
      n_chk++;
      if (decidUseAx[0] !== 1'b0 || decidTarget[0] !== 32'(e))
        $display("FAIL init_entry_lo[%0d]: got useAx=%b tgt=%h expected 0/%h",
                 e, decidUseAx[0], decidTarget[0], 32'(e));
      else n_pass++;
      set_upd(1, p, 0, 1);
      tick();
      set_upd(0, 0, 0, 0);
      #1;
      n_chk++;
      if (decidUseAx[0] !== 1'b1 || decidTarget[0] !== ~32'(e))
        $display("FAIL init_entry_hi[%0d]: got useAx=%b tgt=%h expected 1/%h",
                 e, decidUseAx[0], decidTarget[0], ~32'(e));
      else n_pass++;
      set_upd(1, p, 1, 0);
      tick();
      set_upd(0, 0, 0, 0);
    end
    clear_inputs();
  endtask

  task automatic test_lookup();
    set_lane(0, 1, 32'h100, 1, 32'h200, 1, 32'h300);
    #1;
    n_chk++;
    if (brDecidTaken !== 2'b01)
      $display("FAIL lookup_taken: got %b expected 01", brDecidTaken);
    else n_pass++;
    n_chk++;
    if (decidTarget[0] !== 32'h200)
      $display("FAIL lookup_target: got %h expected 200", decidTarget[0]);
    else n_pass++;
    n_chk++;
    if (decidUseAx !== 2'b00)
      $display("FAIL lookup_useAx: got %b expected 00", decidUseAx);
    else n_pass++;
  endtask

  task automatic test_update_sat();
    set_lane(0, 1, 32'h100, 1, 32'h200, 1, 32'h300);
    set_upd(1, 32'h100, 0, 1);
    tick();
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidTarget[0] !== 32'h300 || decidUseAx[0] !== 1'b1)
      $display("FAIL upd_to_11: got tgt=%h useAx=%b expected 300/1",
               decidTarget[0], decidUseAx[0]);
    else n_pass++;
    set_upd(1, 32'h100, 0, 1);
    tick();
    set_upd(1, 32'h100, 1, 0);
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b1)
      $display("FAIL upd_sat_hi: got useAx=%b expected 1", decidUseAx[0]);
    else n_pass++;
    set_upd(1, 32'h100, 1, 0);
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b0 || decidTarget[0] !== 32'h200)
      $display("FAIL upd_back_01: got useAx=%b tgt=%h expected 0/200",
               decidUseAx[0], decidTarget[0]);
    else n_pass++;
    set_upd(1, 32'h100, 1, 0);
    tick();
    tick();
    set_upd(1, 32'h100, 0, 1);
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b0)
      $display("FAIL upd_sat_lo: got useAx=%b expected 0", decidUseAx[0]);
    else n_pass++;
    set_upd(1, 32'h100, 0, 1);
    tick();
    set_upd(0, 0, 0, 0);
    clear_inputs();
  endtask

  task automatic test_masking();
    set_lane(0, 1, 32'h200, 1, 32'h11, 0, 32'h22);
    set_lane(1, 1, 32'h204, 1, 32'h33, 0, 32'h44);
    #1;
    n_chk++;
    if (brDecidTaken !== 2'b01)
      $display("FAIL mask_both: got %b expected 01", brDecidTaken);
    else n_pass++;
    valid[0] = 1'b0;
    #1;
    n_chk++;
    if (brDecidTaken !== 2'b10)
      $display("FAIL mask_lane0_off: got %b expected 10", brDecidTaken);
    else n_pass++;
    valid[0] = 1'b1;
    btbHit[0] = 1'b0;
    pc[1] = 32'h200;
    #1;
    n_chk++;
    if (brDecidTaken !== 2'b10 || decidTarget[1] !== 32'h33)
      $display("FAIL mask_alias: got %b tgt=%h expected 10/33",
               brDecidTaken, decidTarget[1]);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    set_lane(0, 1, 32'h140, 1, 32'haa, 1, 32'hbb);
    set_upd(1, 32'h140, 0, 1);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b0 || decidTarget[0] !== 32'haa)
      $display("FAIL same_cycle_old: got useAx=%b tgt=%h expected 0/aa",
               decidUseAx[0], decidTarget[0]);
    else n_pass++;
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b1 || decidTarget[0] !== 32'hbb)
      $display("FAIL same_cycle_new: got useAx=%b tgt=%h expected 1/bb",
               decidUseAx[0], decidTarget[0]);
    else n_pass++;
    set_upd(1, 32'h140, 1, 0);
    tick();
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    set_lane(0, 1, 32'h3c0, 1, 32'h1, 1, 32'h2);
    set_upd(1, 32'h3c0, 0, 1);
    tick();
    tick();
    set_upd(0, 0, 0, 0);
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b1)
      $display("FAIL mid_setup: got useAx=%b expected 1", decidUseAx[0]);
    else n_pass++;
    m_run = 1'b0;
    set_upd(1, 32'h3c0, 0, 1);
    rst = 1'b1;
    #3 rst = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    n_chk++;
    if (decidUseAx[0] !== 1'b0 || initDone !== 1'b0)
      $display("FAIL mid_init_noax: got useAx=%b done=%b expected 0/0",
               decidUseAx[0], initDone);
    else n_pass++;
    rst = 1'b1;
    #2 rst = 1'b0;
    set_upd(1, 32'h100, 0, 1);
    while (initDone !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 128) set_upd(1, 32'h3c0, 0, 1);
    end
    set_upd(0, 0, 0, 0);
    n_chk++;
    if (cyc != 256)
      $display("FAIL mid_init_cycles: got %0d expected 256", cyc);
    else n_pass++;
    model_reset();
    m_run = 1'b1;
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b0)
      $display("FAIL mid_3c0_reinit: got useAx=%b expected 0", decidUseAx[0]);
    else n_pass++;
    pc[0] = 32'h100;
    #1;
    n_chk++;
    if (decidUseAx[0] !== 1'b0)
      $display("FAIL mid_100_dropped: got useAx=%b expected 0", decidUseAx[0]);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      int first;
      logic [1:0] e_taken;
      logic [1:0] e_use;
      logic [31:0] e_tgt [2];
      for (int l = 0; l < 2; l++) begin
        logic [31:0] p;
        p = $urandom;
        p[9:2] = 8'(32'h20 + $urandom_range(0, 7));
        set_lane(l, 1'($urandom), p, 1'($urandom), $urandom,
                 1'($urandom), $urandom);
      end
      begin
        logic [31:0] up;
        up = $urandom;
        up[9:2] = 8'(32'h20 + $urandom_range(0, 7));
        set_upd(1'($urandom), up, 1'($urandom), 1'($urandom));
      end
      #1;
      first = -1;
      e_taken = '0;
      e_use = '0;
      for (int l = 0; l < 2; l++) begin
        bit ax;
        bit hit;
        ax = mcnt[idx_of(pc[l])] >= 2;
        hit = ax ? axHit[l] : btbHit[l];
        e_tgt[l] = ax ? axOut[l] : btbOut[l];
        e_use[l] = ax && valid[l];
        if (valid[l] && hit && first < 0) first = l;
      end
      if (first >= 0) e_taken[first] = 1'b1;
      n_chk++;
      if (brDecidTaken !== e_taken)
        $display("FAIL rnd_taken[%0d]: got %b expected %b",
                 it, brDecidTaken, e_taken);
      else n_pass++;
      n_chk++;
      if (decidUseAx !== e_use)
        $display("FAIL rnd_useAx[%0d]: got %b expected %b",
                 it, decidUseAx, e_use);
      else n_pass++;
      n_chk++;
      if (decidTarget[0] !== e_tgt[0] || decidTarget[1] !== e_tgt[1])
        $display("FAIL rnd_target[%0d]: got %h/%h expected %h/%h", it,
                 decidTarget[0], decidTarget[1], e_tgt[0], e_tgt[1]);
      else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_init();
    test_lookup();
    test_update_sat();
    test_masking();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
